pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 49 ++++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master. The controller side is the slave.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rt;
  logic [4:0]  ex_rs_addr;
  logic [4:0]  ex_rt_addr;
  logic [4:0]  ex_write_reg_addr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  mem_write_reg_addr;
  logic        mem_reg_write;
  logic [4:0]  wb_write_reg_addr;
  logic        wb_reg_write;
  logic        mem_branch_taken;
  logic        halt_req;
  logic        halt_ack;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_rs_addr, ex_rt_addr,
           ex_write_reg_addr, ex_reg_write, ex_mem_read,
           mem_write_reg_addr, mem_reg_write, wb_write_reg_addr, wb_reg_write,
           mem_branch_taken, halt_req,
    input  halt_ack, pc_write_en, if_id_write_en, id_ex_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a_sel, fwd_b_sel,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_rs_addr, ex_rt_addr,
           ex_write_reg_addr, ex_reg_write, ex_mem_read,
           mem_write_reg_addr, mem_reg_write, wb_write_reg_addr, wb_reg_write,
           mem_branch_taken, halt_req,
    output halt_ack, pc_write_en, if_id_write_en, id_ex_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a_sel, fwd_b_sel,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller. It handles load-use stalls, branch flushes, EX operand forwarding,
// and a debug halt that first drains the pipeline and then freezes it.
module pipeline_hazard_ctrl (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_drain_cnt, w_drain_cnt_nxt;
  logic [15:0] r_stall_count, r_flush_count;
  logic        w_load_use, w_stall_evt;
  logic        w_pc_we, w_if_id_we, w_bubble, w_flush, w_halt_ack;
  logic [1:0]  w_fwd_a, w_fwd_b;

  // MEM forwarding wins over WB because MEM holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_we, input logic [4:0] mem_rd,
    input logic       wb_we,  input logic [4:0] wb_rd
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return 2'd1;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  assign w_load_use = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_write_reg_addr != 5'd0) &&
                      ((bus.ex_write_reg_addr == bus.id_rs_addr) ||
                       (bus.id_uses_rt && (bus.ex_write_reg_addr == bus.id_rt_addr)));

  // Next-state and control outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_pc_we         = 1'b1;
    w_if_id_we      = 1'b1;
    w_bubble        = 1'b0;
    w_flush         = 1'b0;
    w_halt_ack      = 1'b0;
    w_stall_evt     = 1'b0;
    w_fwd_a         = 2'd0;
    w_fwd_b         = 2'd0;
    if (rst) begin
      w_state_nxt     = S_RUN;
      w_drain_cnt_nxt = 3'd0;
    end else begin
      w_fwd_a = fwd_sel(bus.ex_rs_addr, bus.mem_reg_write, bus.mem_write_reg_addr,
                        bus.wb_reg_write, bus.wb_write_reg_addr);
      w_fwd_b = fwd_sel(bus.ex_rt_addr, bus.mem_reg_write, bus.mem_write_reg_addr,
                        bus.wb_reg_write, bus.wb_write_reg_addr);
      case (r_state)
        S_RUN: begin
          if (bus.mem_branch_taken) begin
            w_flush     = 1'b1;
            w_state_nxt = S_FLUSH;
          end else if (w_load_use) begin
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_bubble    = 1'b1;
            w_stall_evt = 1'b1;
          end else if (bus.halt_req) begin
            w_state_nxt     = S_DRAIN;
            w_drain_cnt_nxt = 3'd4;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        // The ID instruction is already squashed, so a hazard against it is ignored here.
        S_FLUSH: begin
          w_state_nxt = S_RUN;
        end
        S_DRAIN: begin
          w_pc_we    = 1'b0;
          w_if_id_we = 1'b0;
          w_bubble   = 1'b1;
          if (bus.mem_branch_taken) begin
            w_flush = 1'b1;
            w_pc_we = 1'b1;
            if (bus.halt_req) begin
              w_drain_cnt_nxt = 3'd4;
            end else begin
              w_state_nxt     = S_FLUSH;
              w_drain_cnt_nxt = 3'd0;
            end
          end else if (!bus.halt_req) begin
            w_state_nxt     = S_RUN;
            w_drain_cnt_nxt = 3'd0;
          end else if (r_drain_cnt == 3'd1) begin
            w_state_nxt     = S_HALTED;
            w_drain_cnt_nxt = 3'd0;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - 3'd1;
          end
        end
        S_HALTED: begin
          w_pc_we    = 1'b0;
          w_if_id_we = 1'b0;
          w_bubble   = 1'b1;
          w_halt_ack = 1'b1;
          if (!bus.halt_req) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_HALTED;
          end
        end
        default: begin
          w_state_nxt     = S_RUN;
          w_drain_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  // State, drain counter and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_drain_cnt   <= 3'd0;
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      if (w_stall_evt && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign bus.pc_write_en    = w_pc_we;
  assign bus.if_id_write_en = w_if_id_we;
  assign bus.id_ex_bubble   = w_bubble;
  assign bus.if_id_flush    = w_flush;
  assign bus.id_ex_flush    = w_flush;
  assign bus.ex_mem_flush   = w_flush;
  assign bus.halt_ack       = w_halt_ack;
  assign bus.fwd_a_sel      = w_fwd_a;
  assign bus.fwd_b_sel      = w_fwd_b;
  assign bus.stall_count    = r_stall_count;
  assign bus.flush_count    = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed test of pipeline_hazard_ctrl. Each output is checked with an immediate assertion at the falling edge.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The packed vector is {pc_we, if_id_we, bubble, if_id/id_ex/ex_mem flush, halt_ack}.
  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, bus.pc_write_en, bus.if_id_write_en, bus.id_ex_bubble,
              bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.halt_ack},
        {9'd0, exp});
  endtask

  task automatic idle_inputs();
    bus.id_rs_addr = 5'd0;         bus.id_rt_addr = 5'd0;        bus.id_uses_rt = 1'b0;
    bus.ex_rs_addr = 5'd0;         bus.ex_rt_addr = 5'd0;
    bus.ex_write_reg_addr = 5'd0;  bus.ex_reg_write = 1'b0;      bus.ex_mem_read = 1'b0;
    bus.mem_write_reg_addr = 5'd0; bus.mem_reg_write = 1'b0;
    bus.wb_write_reg_addr = 5'd0;  bus.wb_reg_write = 1'b0;
    bus.mem_branch_taken = 1'b0;   bus.halt_req = 1'b0;
  endtask

  task automatic load_use_rs5();
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1;
    bus.ex_write_reg_addr = 5'd5; bus.id_rs_addr = 5'd5;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] RUN_IDLE = 7'b110_000_0;
  localparam logic [6:0] STALL    = 7'b001_000_0;
  localparam logic [6:0] BR_FLUSH = 7'b110_111_0;
  localparam logic [6:0] DRAINING = 7'b001_000_0;
  localparam logic [6:0] DR_BR    = 7'b101_111_0;
  localparam logic [6:0] HALTED   = 7'b001_000_1;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // Reset overrides a hazard, a branch and forwarding matches.
    rst = 1'b1;
    idle_inputs();
    load_use_rs5();
    bus.mem_branch_taken = 1'b1; bus.halt_req = 1'b1;
    bus.mem_reg_write = 1'b1; bus.mem_write_reg_addr = 5'd3; bus.ex_rs_addr = 5'd3; bus.ex_rt_addr = 5'd3;
    @(negedge clk);
    chk_ctrl("rst_outputs", RUN_IDLE);
    chk("rst_fwd", {12'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_stall_cnt", bus.stall_count, 16'd0);
    chk("rst_flush_cnt", bus.flush_count, 16'd0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk_ctrl("run_idle", RUN_IDLE);

    // Load-use on rs
    next_cycle();
    load_use_rs5();
    @(negedge clk);
    chk_ctrl("load_use_rs", STALL);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk_ctrl("after_stall", RUN_IDLE);
    chk("stall_cnt_1", bus.stall_count, 16'd1);

    // Destination r0 never stalls.
    next_cycle();
    load_use_rs5();
    bus.ex_write_reg_addr = 5'd0; bus.id_rs_addr = 5'd0;
    @(negedge clk);
    chk_ctrl("no_stall_r0", RUN_IDLE);
    // rt matches but is not read
    next_cycle();
    load_use_rs5();
    bus.id_rs_addr = 5'd3; bus.id_rt_addr = 5'd5; bus.id_uses_rt = 1'b0;
    @(negedge clk);
    chk_ctrl("no_stall_rt_unused", RUN_IDLE);
    next_cycle();
    bus.id_uses_rt = 1'b1;
    @(negedge clk);
    chk_ctrl("stall_rt_used", STALL);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("stall_cnt_2", bus.stall_count, 16'd2);

    // Branch beats a simultaneous load-use, and FLUSH ignores the hazard.
    next_cycle();
    load_use_rs5();
    bus.mem_branch_taken = 1'b1;
    @(negedge clk);
    chk_ctrl("branch_over_stall", BR_FLUSH);
    next_cycle();
    bus.mem_branch_taken = 1'b0;
    @(negedge clk);
    chk_ctrl("flush_state_idle", RUN_IDLE);
    chk("flush_cnt_1", bus.flush_count, 16'd1);
    chk("stall_cnt_kept", bus.stall_count, 16'd2);
    next_cycle();
    idle_inputs();

    // Halt drain: entry cycle, then 4 DRAIN cycles, then halted.
    bus.halt_req = 1'b1;
    @(negedge clk);
    chk_ctrl("halt_entry", RUN_IDLE);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      @(negedge clk);
      chk_ctrl($sformatf("drain_c%0d", i), DRAINING);
    end
    for (int i = 5; i <= 6; i++) begin
      next_cycle();
      @(negedge clk);
      chk_ctrl($sformatf("halted_c%0d", i), HALTED);
    end
    next_cycle();
    bus.halt_req = 1'b0;
    @(negedge clk);
    chk_ctrl("halted_release", HALTED);
    next_cycle();
    @(negedge clk);
    chk_ctrl("resume_run", RUN_IDLE);

    // A branch on DRAIN cycle 2 reloads the drain, so halt_ack arrives on cycle 7.
    next_cycle();
    bus.halt_req = 1'b1;
    @(negedge clk);
    chk_ctrl("halt2_entry", RUN_IDLE);
    next_cycle();
    @(negedge clk);
    chk_ctrl("halt2_c1", DRAINING);
    next_cycle();
    bus.mem_branch_taken = 1'b1;
    @(negedge clk);
    chk_ctrl("halt2_c2_branch", DR_BR);
    for (int i = 3; i <= 6; i++) begin
      next_cycle();
      bus.mem_branch_taken = 1'b0;
      @(negedge clk);
      chk_ctrl($sformatf("halt2_c%0d", i), DRAINING);
    end
    next_cycle();
    @(negedge clk);
    chk_ctrl("halt2_c7_ack", HALTED);
    chk("flush_cnt_2", bus.flush_count, 16'd2);

    // Reset while halted with halt_req still high
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk_ctrl("rst_in_halted", RUN_IDLE);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_ctrl("post_rst_run", RUN_IDLE);
    chk("post_rst_stall_cnt", bus.stall_count, 16'd0);
    chk("post_rst_flush_cnt", bus.flush_count, 16'd0);
    next_cycle();
    @(negedge clk);
    chk_ctrl("post_rst_drain", DRAINING);
    next_cycle();
    bus.halt_req = 1'b0;
    @(negedge clk);
    chk_ctrl("drain_drop", DRAINING);
    next_cycle();
    @(negedge clk);
    chk_ctrl("drain_drop_run", RUN_IDLE);

    // Forwarding
    next_cycle();
    bus.mem_reg_write = 1'b1; bus.mem_write_reg_addr = 5'd7;
    bus.wb_reg_write = 1'b1;  bus.wb_write_reg_addr = 5'd7;
    bus.ex_rs_addr = 5'd7;    bus.ex_rt_addr = 5'd7;
    @(negedge clk);
    chk("fwd_mem_ab", {12'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'h5);
    bus.mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_ab", {12'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'hA);
    bus.ex_rt_addr = 5'd9;
    #1;
    chk("fwd_wb_a_only", {12'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'h8);
    bus.mem_reg_write = 1'b1; bus.mem_write_reg_addr = 5'd0;
    bus.wb_write_reg_addr = 5'd0; bus.ex_rs_addr = 5'd0; bus.ex_rt_addr = 5'd0;
    #1;
    chk("fwd_r0_none", {12'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
